pic_inta_sequencer: RTL and testbench

Clocked interrupt-acknowledge responder of the 8259-style PIC. Sits between the interrupt block (request register, priority resolver, combinational in-service view) and the CPU bus: raises `int_out` toward the CPU, runs the two-pulse INTA handshake, drives the 8-bit vector on the second pulse, and owns the registered in-service register (ISR) with fully-nested priority and EOI handling. Issues a one-cycle clear back to the interrupt block so edge-triggered requests are consumed.

---
 rtl/pic_pkg.sv | 42 ++++
 rtl/pic_prio_enc.sv | 19 +
 rtl/pic_inta_sequencer.sv | 159 +++++++++++++++
 tb/tb_pic_inta_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared types and helpers for the PIC interrupt-acknowledge sequencer.
package pic_pkg;

    localparam int unsigned NUM_LVL = 8;
    localparam int unsigned LVL_W   = 3;
    localparam int unsigned BASE_W  = 5;
    localparam int unsigned DATA_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PENDING = 3'd1,
        ST_ACK1    = 3'd2,
        ST_WAIT2   = 3'd3,
        ST_ACK2    = 3'd4
    } state_t;

    typedef struct packed {
        logic             found;
        logic [LVL_W-1:0] idx;
    } prio_t;

    // Lowest set bit wins (bit 0 is the highest priority level).
    function automatic prio_t prio_index(input logic [NUM_LVL-1:0] vec);
        prio_t r;
        r.found = 1'b0;
        r.idx   = '0;
        for (int i = NUM_LVL - 1; i >= 0; i--) begin
            if (vec[i]) begin
                r.found = 1'b1;
                r.idx   = LVL_W'(i);
            end
        end
        return r;
    endfunction

    // Vector byte presented on the second INTA pulse.
    function automatic logic [DATA_W-1:0] mk_vector(input logic [BASE_W-1:0] base,
                                                    input logic [LVL_W-1:0]  lvl);
        return {base, lvl};
    endfunction

endpackage

// File: rtl/pic_prio_enc.sv
// 8-bit lowest-set-bit encoder with valid flag.
module pic_prio_enc
    import pic_pkg::*;
(
    input  logic [7:0] req,
    output logic [2:0] idx_c,
    output logic       valid_c
);

    prio_t p;

    // Encode the highest-priority (lowest-index) set bit.
    always_comb begin
        p       = prio_index(req);
        idx_c   = p.idx;
        valid_c = p.found;
    end

endmodule

// File: rtl/pic_inta_sequencer.sv
// INTA handshake responder: int_out, vector drive, clear pulse and in-service register.
module pic_inta_sequencer
    import pic_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       int_req,
    input  logic [7:0] chosen,
    input  logic       inta_n,
    input  logic [4:0] vector_base,
    input  logic       aeoi,
    input  logic       eoi,
    output logic       int_out,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       clear,
    output logic [7:0] clear_mask,
    output logic [7:0] isr
);

    state_t            state_q, state_d;
    logic              int_out_q, int_out_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              data_oe_q, data_oe_d;
    logic              clear_q, clear_d;
    logic [NUM_LVL-1:0] clear_mask_q, clear_mask_d;
    logic [NUM_LVL-1:0] isr_q, isr_d;
    logic              inta_q;
    logic [LVL_W-1:0]  lvl_q, lvl_d;
    logic              spur_q, spur_d;

    logic [LVL_W-1:0]  ch_idx, top_idx;
    logic              ch_vld, top_vld;
    logic              fall, rise, eligible;
    logic [NUM_LVL-1:0] isr_set, isr_clr, isr_eoi;

    pic_prio_enc u_enc_chosen (
        .req     (chosen),
        .idx_c   (ch_idx),
        .valid_c (ch_vld)
    );

    pic_prio_enc u_enc_isr (
        .req     (isr_q),
        .idx_c   (top_idx),
        .valid_c (top_vld)
    );

    assign fall     = !inta_n && inta_q;
    assign rise     = inta_n && !inta_q;
    // With nothing in service any level is eligible; otherwise only strictly higher priority.
    assign eligible = int_req && ch_vld && (!top_vld || (ch_idx < top_idx));

    // Next-state, output and ISR update logic.
    always_comb begin
        state_d      = state_q;
        int_out_d    = int_out_q;
        data_out_d   = data_out_q;
        data_oe_d    = data_oe_q;
        clear_d      = 1'b0;
        clear_mask_d = '0;
        lvl_d        = lvl_q;
        spur_d       = spur_q;
        isr_set      = '0;
        isr_clr      = '0;
        isr_eoi      = '0;

        case (state_q)
            ST_IDLE: begin
                if (eligible) begin
                    state_d   = ST_PENDING;
                    int_out_d = 1'b1;
                end
            end
            ST_PENDING: begin
                if (fall) begin
                    state_d   = ST_ACK1;
                    int_out_d = 1'b0;
                    if (ch_vld) begin
                        lvl_d        = ch_idx;
                        spur_d       = 1'b0;
                        isr_set      = NUM_LVL'(1) << ch_idx;
                        clear_d      = 1'b1;
                        clear_mask_d = chosen;
                    end else begin
                        // Request withdrawn before the acknowledge: answer with level 7.
                        lvl_d  = LVL_W'(NUM_LVL - 1);
                        spur_d = 1'b1;
                    end
                end
            end
            ST_ACK1: begin
                if (rise) begin
                    state_d = ST_WAIT2;
                end
            end
            ST_WAIT2: begin
                if (fall) begin
                    state_d    = ST_ACK2;
                    data_out_d = mk_vector(vector_base, lvl_q);
                    data_oe_d  = 1'b1;
                end
            end
            ST_ACK2: begin
                if (rise) begin
                    state_d   = ST_IDLE;
                    data_oe_d = 1'b0;
                    if (aeoi && !spur_q) begin
                        isr_clr = NUM_LVL'(1) << lvl_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // EOI retires the current top level before any new bit is ORed in.
        if (eoi && top_vld) begin
            isr_eoi = NUM_LVL'(1) << top_idx;
        end
        isr_d = (isr_q & ~isr_eoi & ~isr_clr) | isr_set;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            int_out_q    <= 1'b0;
            data_out_q   <= '0;
            data_oe_q    <= 1'b0;
            clear_q      <= 1'b0;
            clear_mask_q <= '0;
            isr_q        <= '0;
            inta_q       <= 1'b1;
            lvl_q        <= '0;
            spur_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            int_out_q    <= int_out_d;
            data_out_q   <= data_out_d;
            data_oe_q    <= data_oe_d;
            clear_q      <= clear_d;
            clear_mask_q <= clear_mask_d;
            isr_q        <= isr_d;
            inta_q       <= inta_n;
            lvl_q        <= lvl_d;
            spur_q       <= spur_d;
        end
    end

    assign int_out    = int_out_q;
    assign data_out   = data_out_q;
    assign data_oe    = data_oe_q;
    assign clear      = clear_q;
    assign clear_mask = clear_mask_q;
    assign isr        = isr_q;

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Self-checking bench for pic_inta_sequencer with clear/vector scoreboards.
module tb_pic_inta_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       int_req;
    logic [7:0] chosen;
    logic       inta_n;
    logic [4:0] vector_base;
    logic       aeoi;
    logic       eoi;
    logic       int_out;
    logic [7:0] data_out;
    logic       data_oe;
    logic       clear;
    logic [7:0] clear_mask;
    logic [7:0] isr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] clr_q[$];
    logic [7:0] vec_q[$];
    logic [7:0] m_exp;
    logic       prev_oe = 1'b0;

    pic_inta_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .int_req     (int_req),
        .chosen      (chosen),
        .inta_n      (inta_n),
        .vector_base (vector_base),
        .aeoi        (aeoi),
        .eoi         (eoi),
        .int_out     (int_out),
        .data_out    (data_out),
        .data_oe     (data_oe),
        .clear       (clear),
        .clear_mask  (clear_mask),
        .isr         (isr)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every clear cycle and every vector drive must be expected.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            prev_oe = 1'b0;
        end else begin
            if (clear) begin
                n_checks++;
                if (clr_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL clear_unexpected: clear_mask=%h, required no clear pulse", clear_mask);
                end else begin
                    m_exp = clr_q.pop_front();
                    if (clear_mask !== m_exp) begin
                        n_fail++;
                        $display("FAIL clear_mask: got %h, expected %h", clear_mask, m_exp);
                    end
                end
            end
            if (data_oe && !prev_oe) begin
                n_checks++;
                if (vec_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL vector_unexpected: data_out=%h, required no drive", data_out);
                end else begin
                    m_exp = vec_q.pop_front();
                    if (data_out !== m_exp) begin
                        n_fail++;
                        $display("FAIL vector: got %h, expected %h", data_out, m_exp);
                    end
                end
            end
            prev_oe = data_oe;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_int();
        for (int i = 0; i < 8; i++) begin
            tick();
            if (int_out === 1'b1) break;
        end
        n_checks++;
        if (int_out !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_int: int_out=%b, expected 1 within 8 clocks", int_out);
        end
    endtask

    // Full two-pulse acknowledge; the request is consumed after the first fall.
    task automatic do_ack(input logic [7:0] exp_clear, input logic [7:0] exp_vec, input bit spur);
        if (!spur) clr_q.push_back(exp_clear);
        inta_n = 1'b0;
        tick();
        int_req = 1'b0;
        chosen  = 8'h00;
        repeat (2) tick();
        inta_n = 1'b1;
        repeat (3) tick();
        vec_q.push_back(exp_vec);
        inta_n = 1'b0;
        repeat (3) tick();
        inta_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; int_req = 1'b0; chosen = 8'h00; inta_n = 1'b1;
        vector_base = 5'h08; aeoi = 1'b0; eoi = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        n_checks += 6;
        if (int_out !== 1'b0)     begin n_fail++; $display("FAIL rst_int_out: got %b, expected 0", int_out); end
        if (data_oe !== 1'b0)     begin n_fail++; $display("FAIL rst_data_oe: got %b, expected 0", data_oe); end
        if (data_out !== 8'h00)   begin n_fail++; $display("FAIL rst_data_out: got %h, expected 00", data_out); end
        if (clear !== 1'b0)       begin n_fail++; $display("FAIL rst_clear: got %b, expected 0", clear); end
        if (clear_mask !== 8'h00) begin n_fail++; $display("FAIL rst_clear_mask: got %h, expected 00", clear_mask); end
        if (isr !== 8'h00)        begin n_fail++; $display("FAIL rst_isr: got %h, expected 00", isr); end
    endtask

    task automatic test_basic();
        vector_base = 5'h08; chosen = 8'h08; int_req = 1'b1;
        tick();
        n_checks++;
        if (int_out !== 1'b1) begin n_fail++; $display("FAIL basic_int_rise: got %b, expected 1", int_out); end
        clr_q.push_back(8'h08);
        inta_n = 1'b0;
        tick();
        n_checks += 2;
        if (int_out !== 1'b0) begin n_fail++; $display("FAIL basic_int_drop: got %b, expected 0", int_out); end
        if (isr !== 8'h08)    begin n_fail++; $display("FAIL basic_isr_set: got %h, expected 08", isr); end
        int_req = 1'b0; chosen = 8'h00;
        repeat (2) tick();
        inta_n = 1'b1;
        repeat (3) tick();
        vec_q.push_back(8'h43);
        inta_n = 1'b0;
        tick();
        n_checks += 2;
        if (data_oe !== 1'b1)    begin n_fail++; $display("FAIL basic_oe_on: got %b, expected 1", data_oe); end
        if (data_out !== 8'h43)  begin n_fail++; $display("FAIL basic_data: got %h, expected 43", data_out); end
        repeat (2) tick();
        n_checks++;
        if (data_oe !== 1'b1) begin n_fail++; $display("FAIL basic_oe_hold: got %b, expected 1", data_oe); end
        inta_n = 1'b1;
        tick();
        n_checks += 2;
        if (data_oe !== 1'b0) begin n_fail++; $display("FAIL basic_oe_off: got %b, expected 0", data_oe); end
        if (isr !== 8'h08)    begin n_fail++; $display("FAIL basic_isr_keep: got %h, expected 08", isr); end
        repeat (2) tick();
    endtask

    task automatic test_nesting();
        chosen = 8'h02; int_req = 1'b1;
        wait_int();
        do_ack(8'h02, 8'h41, 1'b0);
        n_checks++;
        if (isr !== 8'h0A) begin n_fail++; $display("FAIL nest_isr: got %h, expected 0A", isr); end
        chosen = 8'h20; int_req = 1'b1;
        repeat (4) tick();
        n_checks++;
        if (int_out !== 1'b0) begin n_fail++; $display("FAIL nest_lower_blocked: got %b, expected 0", int_out); end
        chosen = 8'h00; int_req = 1'b0;
        tick();
    endtask

    task automatic test_eoi();
        logic [7:0] exp_isr [3];
        exp_isr[0] = 8'h08; exp_isr[1] = 8'h00; exp_isr[2] = 8'h00;
        for (int i = 0; i < 3; i++) begin
            eoi = 1'b1;
            tick();
            eoi = 1'b0;
            n_checks++;
            if (isr !== exp_isr[i]) begin n_fail++; $display("FAIL eoi_%0d: got %h, expected %h", i, isr, exp_isr[i]); end
        end
        tick();
    endtask

    task automatic test_aeoi();
        aeoi = 1'b1; vector_base = 5'h12; chosen = 8'h80; int_req = 1'b1;
        wait_int();
        do_ack(8'h80, 8'h97, 1'b0);
        n_checks++;
        if (isr !== 8'h00) begin n_fail++; $display("FAIL aeoi_isr: got %h, expected 00", isr); end
        aeoi = 1'b0; vector_base = 5'h08;
        tick();
    endtask

    task automatic test_spurious();
        chosen = 8'h04; int_req = 1'b1;
        wait_int();
        do_ack(8'h04, 8'h42, 1'b0);
        n_checks++;
        if (isr !== 8'h04) begin n_fail++; $display("FAIL spur_setup_isr: got %h, expected 04", isr); end
        chosen = 8'h02; int_req = 1'b1;
        wait_int();
        chosen = 8'h00; int_req = 1'b0;
        tick();
        do_ack(8'h00, 8'h47, 1'b1);
        n_checks++;
        if (isr !== 8'h04) begin n_fail++; $display("FAIL spur_isr: got %h, expected 04", isr); end
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        n_checks++;
        if (isr !== 8'h00) begin n_fail++; $display("FAIL spur_eoi: got %h, expected 00", isr); end
    endtask

    task automatic test_reset_ack2();
        chosen = 8'h01; int_req = 1'b1;
        wait_int();
        clr_q.push_back(8'h01);
        inta_n = 1'b0;
        tick();
        int_req = 1'b0; chosen = 8'h00;
        repeat (2) tick();
        inta_n = 1'b1;
        repeat (3) tick();
        vec_q.push_back(8'h40);
        inta_n = 1'b0;
        tick();
        n_checks++;
        if (data_oe !== 1'b1) begin n_fail++; $display("FAIL rack2_oe_on: got %b, expected 1", data_oe); end
        #3;
        rst = 1'b1;
        #1;
        n_checks += 3;
        if (data_oe !== 1'b0) begin n_fail++; $display("FAIL rack2_oe_async: got %b, expected 0", data_oe); end
        if (isr !== 8'h00)    begin n_fail++; $display("FAIL rack2_isr_async: got %h, expected 00", isr); end
        if (int_out !== 1'b0) begin n_fail++; $display("FAIL rack2_int_async: got %b, expected 0", int_out); end
        tick();
        rst = 1'b0;
        repeat (3) tick();
        inta_n = 1'b1;
        repeat (3) tick();
        n_checks += 2;
        if (data_oe !== 1'b0) begin n_fail++; $display("FAIL rack2_no_vector: got %b, expected 0", data_oe); end
        if (isr !== 8'h00)    begin n_fail++; $display("FAIL rack2_isr_after: got %h, expected 00", isr); end
    endtask

    task automatic test_drain();
        n_checks += 2;
        if (clr_q.size() != 0) begin n_fail++; $display("FAIL clear_missing: %0d pending, expected 0", clr_q.size()); end
        if (vec_q.size() != 0) begin n_fail++; $display("FAIL vector_missing: %0d pending, expected 0", vec_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_nesting();
        test_eoi();
        test_aeoi();
        test_spurious();
        test_reset_ack2();
        test_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
